// File: rtl/combo_input_engine.sv
// combo_input_engine: history-buffer combo recogniser that turns direction/attack edges into move requests.
// Optional COMBO_MIRROR_EN: swap left/right codes for a left-facing fighter. Rev 1.0
`default_nettype none

module combo_input_engine #(
  parameter int NUM_COMBOS = 2,
  parameter int MAX_LEN    = 8,
  parameter int TIMEOUT    = 10_000_000,
  parameter int MOVE_W     = $clog2(NUM_COMBOS + 2)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          up,
  input  logic                          down,
  input  logic                          left,
  input  logic                          right,
  input  logic                          attack,
  input  logic                          can_attack,
  input  logic                          facing_left,
  input  logic [NUM_COMBOS*MAX_LEN*2-1:0] combo_seq,
  input  logic [NUM_COMBOS*4-1:0]       combo_len,
  output logic                          move_valid,
  output logic [MOVE_W-1:0]             move_code,
  output logic [3:0]                    hist_count
);

  localparam int c_tmr_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int c_idx_w = $clog2(MAX_LEN);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 2);

  logic [3:0]          r_prev_dir;
  logic                r_prev_atk;
  logic [1:0]          r_hist [MAX_LEN];
  logic [3:0]          r_count;
  logic [c_tmr_w-1:0]  r_timer;
  logic                r_move_valid;
  logic [MOVE_W-1:0]   r_move_code;

  logic [3:0]          w_dir_lvl;
  logic [3:0]          w_dir_rise;
  logic                w_atk_rise;
  logic                w_push;
  logic [1:0]          w_code;
  logic [MOVE_W-1:0]   w_match_code;
  int                  w_len;
  logic                w_hit;

  assign w_dir_lvl  = {right, left, down, up};
  assign w_dir_rise = w_dir_lvl & ~r_prev_dir;
  assign w_atk_rise = attack & ~r_prev_atk;
  assign w_push     = |w_dir_rise;

  always_comb begin
    w_code = 2'd3;
    if (w_dir_rise[0])      w_code = 2'd0;
    else if (w_dir_rise[1]) w_code = 2'd1;
    else if (w_dir_rise[2]) w_code = 2'd2;
`ifdef COMBO_MIRROR_EN
    if (facing_left && w_code[1]) w_code[0] = ~w_code[0];
`endif
  end

`ifndef COMBO_MIRROR_EN
  logic w_unused_facing;
  assign w_unused_facing = facing_left;
`endif

  // r_hist[0] is the newest entry, so combo step i lines up with r_hist[len-1-i].
  always_comb begin
    w_match_code = MOVE_W'(1);
    w_len        = 0;
    w_hit        = 1'b0;
    for (int k = 0; k < NUM_COMBOS; k++) begin
      w_len = int'(combo_len[k*4 +: 4]);
      w_hit = (w_len != 0) && (w_len <= int'(r_count)) && (w_len <= MAX_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        if (w_hit && (i < w_len)) begin
          if (combo_seq[(k*MAX_LEN + i)*2 +: 2] != r_hist[c_idx_w'(w_len - 1 - i)])
            w_hit = 1'b0;
        end
      end
      if (w_hit) w_match_code = MOVE_W'(k + 2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_dir   <= '0;
      r_prev_atk   <= 1'b0;
      r_count      <= '0;
      r_timer      <= '0;
      r_move_valid <= 1'b0;
      r_move_code  <= '0;
      for (int i = 0; i < MAX_LEN; i++) r_hist[i] <= 2'd0;
    end else begin
      r_prev_dir   <= w_dir_lvl;
      r_prev_atk   <= attack;
      r_move_valid <= 1'b0;
      r_move_code  <= '0;
      if (w_atk_rise) begin
        if (can_attack) begin
          r_move_valid <= 1'b1;
          r_move_code  <= w_match_code;
        end
        r_count <= '0;
        r_timer <= '0;
      end else if (w_push) begin
        r_hist[0] <= w_code;
        for (int i = 1; i < MAX_LEN; i++) r_hist[i] <= r_hist[i-1];
        if (r_count < 4'(MAX_LEN)) r_count <= r_count + 4'd1;
        r_timer <= '0;
      end else if (r_count != 4'd0) begin
        if (r_timer == c_tmr_last) begin
          r_count <= '0;
          r_timer <= '0;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end
    end
  end

  assign move_valid = r_move_valid;
  assign move_code  = r_move_code;
  assign hist_count = r_count;

endmodule

`default_nettype wire

// File: doc/combo_input_engine.md
# combo_input_engine

Parametrised combo-recognition engine for one fighter: turns debounced direction/attack levels into a registered one-cycle attack request carrying a move code (normal attack or one of `NUM_COMBOS` runtime-programmable directional combos). It sits between the per-player debouncers and the game-state logic, replacing fixed per-combo detectors with a single history buffer matched against a pattern table. The same engine serves human players and, fed from a bot driver, CPU opponents.

## Interface
- `NUM_COMBOS`, 2: number of programmable combos (1..8).
- `MAX_LEN`, 8: history depth and maximum combo length in direction steps (2..15).
- `TIMEOUT`, 10_000_000: idle cycles after the last direction press before history is cleared (≥2).
- `MOVE_W`, `$clog2(NUM_COMBOS+2)`: width of `move_code` (derived; do not override).

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `up`, `down`, `left`, `right`  in  1 each  debounced direction levels.
- `attack`  in  1  debounced attack level.
- `can_attack`  in  1  high when the fighter is not stunned/mid-animation.
- `facing_left`  in  1  fighter orientation (used only with `COMBO_MIRROR_EN`).
- `combo_seq`  in  `NUM_COMBOS*MAX_LEN*2`  pattern table; combo k step i at bits `[(k*MAX_LEN+i)*2 +: 2]`, step 0 oldest.
- `combo_len`  in  `NUM_COMBOS*4`  length of combo k at `[k*4 +: 4]`; 0 disables it.
- `move_valid`  out  1  one-cycle attack request.
- `move_code`  out  `MOVE_W`  1 = normal, k+2 = combo k; 0 when `move_valid` low.
- `hist_count`  out  4  current history fill level.

## Operation
- Direction codes: up=0, down=1, left=2, right=3.
- Rising edges detected against registered previous levels (prev regs reset to 0; a level high out of reset is an edge on the first cycle).
- Direction push: on any direction rising edge, one code is pushed; simultaneous edges resolved up > down > left > right, others discarded.
- Buffer full (`hist_count == MAX_LEN`): push shifts out oldest entry; count saturates.
- Idle timer: counts while `hist_count > 0` and no push; reloads to 0 on each push; on reaching `TIMEOUT-1` history clears (count=0, timer=0).
- Attack edge with `can_attack` high: evaluated against history *before* this cycle's push. Combo k matches iff `combo_len[k] != 0`, `combo_len[k] <= hist_count`, `combo_len[k] <= MAX_LEN`, and the newest `combo_len[k]` entries equal steps 0..len-1 in order. Highest matching k wins; no match → code 1.
- Any attack edge (accepted or not) clears history and timer; a same-cycle direction edge is dropped.
- Attack edge with `can_attack` low: no request, history still cleared.
- Holding attack never repeats a request; only rising edges count.
- `combo_seq`/`combo_len` are sampled combinationally at evaluation time; changes take effect next edge.

## Timing
- Reset: `move_valid`=0, `move_code`=0, `hist_count`=0, history, timer and edge registers 0.
- Latency: attack rising edge sampled at cycle n → `move_valid`/`move_code` high for exactly cycle n+1.
- Push at cycle n → `hist_count` reflects it at n+1.
- Timeout: last push at cycle n → history cleared at edge ending cycle n+TIMEOUT-1 (`hist_count`=0 visible cycle n+TIMEOUT).
- Back-to-back attack edges (attack low one cycle between) give back-to-back requests, each code 1 after the first.
- `rst_n` asserted mid-operation clears everything immediately, including an in-flight `move_valid`.

## Configuration
- `COMBO_MIRROR_EN` defined: when `facing_left`=1, left and right codes are swapped before push, so patterns are written for a right-facing fighter.
- Not defined: `facing_left` ignored; codes pushed as pressed.

## Test plan
- `NUM_COMBOS`=2, `TIMEOUT`=16; combo0 = left,down,right (len 3); press left,down,right then attack → `move_valid` one cycle, `move_code`=2.
- combo1 = up,up,down,down,left,right,left,right (len 8), combo0 as above; press full combo1 then attack → code 3 (highest index wins though combo0 tail also matches).
- Press left,down, wait 20 idle cycles, press right, attack → `hist_count`=0 after cycle 16 idle, code 1.
- Push 10 directions into `MAX_LEN`=8; `hist_count` saturates at 8; last 3 = combo0 → code 2; hold attack 100 cycles → single request; `can_attack`=0 edge → no request, `hist_count`=0.
- Up and right rise same cycle → only up pushed (`hist_count`=1); direction and attack same cycle → direction dropped, code evaluated on prior history.
- With `COMBO_MIRROR_EN`, `facing_left`=1, press right,down,left, attack → code 2; without macro → code 1.
